mem_arbiter: RTL and testbench

Shares one single-port unified instruction/data memory between the core's instruction-fetch port (IF) and load/store port (D). Exactly one memory transaction is outstanding at a time. Arbitration is fixed-priority toward D with a starvation limit that guarantees fetch progress. The block sits between the RISCV core and the memory model and replaces the core's separate instruction and data memories.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and load/store (D).
// One transaction in flight at a time; D has priority, with a starvation limit that lets IF through.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LW     = $clog2(MEM_LAT + 1);
  localparam int SW     = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_next;
  logic [LW-1:0]   lat_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            owner;      // 0 = IF, 1 = D
  logic            owner_we;
  logic            if_win, d_win;
  logic            lat_done;

  assign lat_done = (lat_cnt == LW'(MEM_LAT));
  assign busy     = (state == WAIT);

  // Arbitration; grants stay low while reset is asserted.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (reset && state == IDLE) begin
      if (d_req && !(if_req && starve_cnt == SW'(STARVE_MAX)))
        d_win = 1'b1;
      else if (if_req)
        if_win = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (if_win || d_win) state_next = WAIT;
      WAIT: if (lat_done)        state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = if_win;
    d_gnt     = d_win;
    mem_en    = if_win || d_win;
    mem_we    = d_win && d_we;
    mem_addr  = d_win ? d_addr : if_addr;
    mem_wdata = d_win ? d_wdata : '0;
    mem_wstrb = (d_win && d_we) ? d_wstrb : {STRB_W{1'b0}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner      <= 1'b0;
      owner_we   <= 1'b0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (if_win || d_win) begin
        owner    <= d_win;
        owner_we <= d_win && d_we;
        lat_cnt  <= LW'(1);
        if (if_win)
          starve_cnt <= '0;
        else if (if_req && starve_cnt != SW'(STARVE_MAX))
          starve_cnt <= starve_cnt + SW'(1);
      end else if (state == WAIT) begin
        if (lat_done) begin
          // Stores complete with an acknowledge only, so their read data is zeroed.
          if (owner) begin
            d_rvalid <= 1'b1;
            d_rdata  <= owner_we ? '0 : mem_rdata;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
          end
        end else begin
          lat_cnt <= lat_cnt + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small fixed-latency memory model.
module tb_mem_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int tests_run = 0;
  int tests_failed = 0;

  int          q_if_gnt[$], q_d_gnt[$], q_if_rv[$], q_d_rv[$];
  logic [31:0] q_if_data[$], q_d_data[$];
  logic [15:0] order;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: data is presented only in cycle issue+MEM_LAT, garbage otherwise.
  logic [31:0] mem [0:255];
  bit   [255:0] written;
  logic [7:0]  rd_idx;
  logic [2:0]  mcnt = 3'd0;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'd4) ? 32'h0050_0093 : (32'h1000_0000 + 32'(a));
  endfunction

  function automatic logic [31:0] read_word(input logic [7:0] a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_en) begin
      rd_idx <= mem_addr[9:2];
      mcnt   <= 3'd1;
      if (mem_we) begin
        w = read_word(mem_addr[9:2]);
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        mem[mem_addr[9:2]]     <= w;
        written[mem_addr[9:2]] <= 1'b1;
      end
    end else if (mcnt != 3'd0 && mcnt != 3'd7) begin
      mcnt <= mcnt + 3'd1;
    end
  end

  assign mem_rdata = (mcnt == 3'(MEM_LAT)) ? read_word(rd_idx) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_if_gnt.delete(); q_d_gnt.delete(); q_if_rv.delete(); q_d_rv.delete();
    q_if_data.delete(); q_d_data.delete();
    order = '0;
  endtask

  task automatic drain();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    repeat (5) wait_cycle();
  endtask

  // Runs n cycles from the current one (cycle 0), logging grants and responses.
  // A requester with keep=1 re-requests the next word right after each grant.
  task automatic run_cycles(input int n, input bit if_keep, input bit d_keep);
    for (int c = 0; c < n; c++) begin
      bit ig, dg;
      #2;
      ig = if_gnt;
      dg = d_gnt;
      if (ig) begin q_if_gnt.push_back(c); order = {order[14:0], 1'b0}; end
      if (dg) begin q_d_gnt.push_back(c);  order = {order[14:0], 1'b1}; end
      if (if_rvalid) begin q_if_rv.push_back(c); q_if_data.push_back(if_rdata); end
      if (d_rvalid)  begin q_d_rv.push_back(c);  q_d_data.push_back(d_rdata);  end
      wait_cycle();
      if (ig) begin
        check("starve_clr", 32'(dut.starve_cnt), 32'd0);
        if (if_keep) if_addr = if_addr + 32'd4;
        else         if_req  = 1'b0;
      end
      if (dg) begin
        if (d_keep) d_addr = d_addr + 32'd4;
        else        d_req  = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    clear_log();

    // Reset state, and grants held off while reset is low.
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    if_req = 1'b1;
    #1;
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    wait_cycle();
    if_req = 1'b0;
    wait_cycle();
    reset = 1'b1;
    wait_cycle();
    check("idle_mem_en", 32'(mem_en), 32'd0);
    $display("[TB] reset checks done");

    // Single fetch.
    if_req = 1'b1; if_addr = 32'h10;
    #2;
    check("sf_if_gnt", 32'(if_gnt), 32'd1);
    check("sf_mem_en", 32'(mem_en), 32'd1);
    check("sf_mem_addr", mem_addr, 32'h10);
    check("sf_mem_we", 32'(mem_we), 32'd0);
    check("sf_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("sf_busy0", 32'(busy), 32'd0);
    wait_cycle();
    if_req = 1'b0;
    #2;
    check("sf_busy1", 32'(busy), 32'd1);
    check("sf_mem_en1", 32'(mem_en), 32'd0);
    check("sf_rvalid1", 32'(if_rvalid), 32'd0);
    wait_cycle(); #2;
    check("sf_busy2", 32'(busy), 32'd1);
    check("sf_rvalid2", 32'(if_rvalid), 32'd0);
    wait_cycle(); #2;
    check("sf_rvalid3", 32'(if_rvalid), 32'd1);
    check("sf_rdata3", if_rdata, 32'h0050_0093);
    check("sf_d_rvalid3", 32'(d_rvalid), 32'd0);
    check("sf_busy3", 32'(busy), 32'd0);
    wait_cycle(); #2;
    check("sf_rvalid4", 32'(if_rvalid), 32'd0);
    check("sf_rdata_hold", if_rdata, 32'h0050_0093);
    wait_cycle();
    $display("[TB] single fetch done");

    // Contention: D load wins first, IF follows back-to-back.
    clear_log();
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    run_cycles(8, 1'b0, 1'b0);
    check("ct_d_gnt_n", 32'(q_d_gnt.size()), 32'd1);
    check("ct_d_gnt", 32'(q_d_gnt[0]), 32'd0);
    check("ct_d_rv", 32'(q_d_rv[0]), 32'd3);
    check("ct_d_data", q_d_data[0], 32'h1000_0080);
    check("ct_if_gnt_n", 32'(q_if_gnt.size()), 32'd1);
    check("ct_if_gnt", 32'(q_if_gnt[0]), 32'd3);
    check("ct_if_rv", 32'(q_if_rv[0]), 32'd6);
    check("ct_if_data", q_if_data[0], 32'h1000_0008);
    drain();
    $display("[TB] contention done");

    // Starvation limit: both held continuously.
    clear_log();
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    run_cycles(16, 1'b1, 1'b1);
    check("sv_gnt_count", 32'(q_if_gnt.size() + q_d_gnt.size()), 32'd6);
    check("sv_order", 32'(order), 32'h36);
    check("sv_if_gnt2", 32'(q_if_gnt[1]), 32'd15);
    drain();
    $display("[TB] starvation done");

    // Store with partial strobes, then read it back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    #2;
    check("st_d_gnt", 32'(d_gnt), 32'd1);
    check("st_mem_en", 32'(mem_en), 32'd1);
    check("st_mem_we", 32'(mem_we), 32'd1);
    check("st_mem_wstrb", 32'(mem_wstrb), 32'h3);
    check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_mem_addr", mem_addr, 32'h100);
    wait_cycle();
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) wait_cycle();
    #2;
    check("st_d_rvalid", 32'(d_rvalid), 32'd1);
    check("st_d_rdata", d_rdata, 32'd0);
    wait_cycle(); #2;
    check("st_d_rvalid_pulse", 32'(d_rvalid), 32'd0);
    wait_cycle();
    clear_log();
    d_req = 1'b1; d_addr = 32'h100;
    run_cycles(5, 1'b0, 1'b0);
    check("ld_rv", 32'(q_d_rv[0]), 32'd3);
    check("ld_data", q_d_data[0], 32'h1000_BEEF);
    drain();
    $display("[TB] store done");

    // Back-to-back fetches.
    clear_log();
    if_req = 1'b1; if_addr = 32'h0;
    run_cycles(7, 1'b1, 1'b0);
    check("bb_gnt_n", 32'(q_if_gnt.size()), 32'd3);
    check("bb_gnt1", 32'(q_if_gnt[1]), 32'd3);
    check("bb_rv0", 32'(q_if_rv[0]), 32'd3);
    check("bb_rv1", 32'(q_if_rv[1]), 32'd6);
    check("bb_data0", q_if_data[0], 32'h1000_0000);
    check("bb_data1", q_if_data[1], 32'h1000_0001);
    drain();
    $display("[TB] back-to-back done");

    // Reset mid-transaction drops the fetch.
    if_req = 1'b1; if_addr = 32'h10;
    #2;
    check("mr_if_gnt", 32'(if_gnt), 32'd1);
    wait_cycle();
    if_req = 1'b0;
    wait_cycle(); #2;
    check("mr_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mr_busy_now", 32'(busy), 32'd0);
    check("mr_if_rdata", if_rdata, 32'd0);
    clear_log();
    wait_cycle();
    wait_cycle();
    reset = 1'b1;
    run_cycles(5, 1'b0, 1'b0);
    check("mr_no_rvalid", 32'(q_if_rv.size() + q_d_rv.size()), 32'd0);
    clear_log();
    if_req = 1'b1; if_addr = 32'h14;
    run_cycles(5, 1'b0, 1'b0);
    check("mr_new_gnt", 32'(q_if_gnt[0]), 32'd0);
    check("mr_new_rv_n", 32'(q_if_rv.size()), 32'd1);
    check("mr_new_rv", 32'(q_if_rv[0]), 32'd3);
    check("mr_new_data", q_if_data[0], 32'h1000_0005);
    drain();
    $display("[TB] mid-reset done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
